// File: rtl/vga_ball_renderer.sv
// Pixel-colour stage behind the VGA sync generator: draws a bordered background with a
// bouncing square ball and re-times hsync/vsync to match the registered RGB.
module vga_ball_renderer #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned BALL_SIZE  = 8,
  parameter int unsigned SPEED      = 2,
  parameter logic [11:0] BG_RGB     = 12'h008,
  parameter logic [11:0] BALL_RGB   = 12'hFF0,
  parameter logic [11:0] BORDER_RGB = 12'hFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p_tick,
  input  logic        display_on,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        start,
  input  logic        pause,
  output logic [11:0] rgb,
  output logic        hsync_out,
  output logic        vsync_out
);

  localparam logic [9:0]  MaxX    = 10'(H_ACTIVE - BALL_SIZE);
  localparam logic [9:0]  MaxY    = 10'(V_ACTIVE - BALL_SIZE);
  localparam logic [9:0]  CentreX = 10'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [9:0]  CentreY = 10'((V_ACTIVE - BALL_SIZE) / 2);
  localparam logic [10:0] HAct    = 11'(H_ACTIVE);
  localparam logic [10:0] VAct    = 11'(V_ACTIVE);
  localparam logic [10:0] Size    = 11'(BALL_SIZE);

  typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

  state_e      r_state;
  logic [9:0]  r_ball_x;
  logic [9:0]  r_ball_y;
  logic        r_dir_x;
  logic        r_dir_y;
  logic        r_vsync_prev;

  logic [10:0] w_x;
  logic [10:0] w_y;
  logic [10:0] w_bx;
  logic [10:0] w_by;
  logic        w_visible;
  logic        w_border;
  logic        w_in_ball;
  logic        w_frame_tick;
  logic [11:0] w_colour;
  logic [10:0] w_step_x;
  logic [10:0] w_step_y;

  // Returns {new_dir, new_pos}; dir 1 means increasing. 11-bit sum avoids wrap at the edge.
  function automatic logic [10:0] step_axis(input logic [9:0] pos, input logic dir,
                                            input logic [9:0] max_pos);
    logic [10:0] sum;
    logic [9:0]  diff;
    sum  = {1'b0, pos} + 11'(SPEED);
    diff = pos - 10'(SPEED);
    if (dir) begin
      if (sum >= {1'b0, max_pos}) step_axis = {1'b0, max_pos};
      else                        step_axis = {1'b1, sum[9:0]};
    end else begin
      if (pos <= 10'(SPEED)) step_axis = {1'b1, 10'd0};
      else                   step_axis = {1'b0, diff};
    end
  endfunction

  assign w_x  = {1'b0, x};
  assign w_y  = {1'b0, y};
  assign w_bx = {1'b0, r_ball_x};
  assign w_by = {1'b0, r_ball_y};

  assign w_visible = display_on && (w_x < HAct) && (w_y < VAct);
  assign w_border  = (w_x == 11'd0) || (w_x == HAct - 11'd1) ||
                     (w_y == 11'd0) || (w_y == VAct - 11'd1);
  assign w_in_ball = (w_x >= w_bx) && (w_x < w_bx + Size) &&
                     (w_y >= w_by) && (w_y < w_by + Size);

  always_comb begin
    w_colour = BG_RGB;
    if (!w_visible)     w_colour = 12'h000;
    else if (w_border)  w_colour = BORDER_RGB;
    else if (w_in_ball) w_colour = BALL_RGB;
  end

  assign w_frame_tick = !r_vsync_prev && vsync_in;
  assign w_step_x     = step_axis(r_ball_x, r_dir_x, MaxX);
  assign w_step_y     = step_axis(r_ball_y, r_dir_y, MaxY);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb          <= 12'h000;
      hsync_out    <= 1'b1;
      vsync_out    <= 1'b1;
      r_state      <= StIdle;
      r_ball_x     <= CentreX;
      r_ball_y     <= CentreY;
      r_dir_x      <= 1'b1;
      r_dir_y      <= 1'b1;
      r_vsync_prev <= 1'b1;
    end else if (p_tick) begin
      rgb          <= w_colour;
      hsync_out    <= hsync_in;
      vsync_out    <= vsync_in;
      r_vsync_prev <= vsync_in;
      // A state transition on a frame edge suppresses that frame's move.
      unique case (r_state)
        StIdle: if (start) r_state <= StRun;
        StRun: begin
          if (pause) begin
            r_state <= StHold;
          end else if (w_frame_tick) begin
            r_ball_x <= w_step_x[9:0];
            r_dir_x  <= w_step_x[10];
            r_ball_y <= w_step_y[9:0];
            r_dir_y  <= w_step_y[10];
          end
        end
        StHold: if (start && !pause) r_state <= StRun;
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_ball_renderer.sv
// Randomised bench for vga_ball_renderer with a frame-level behavioural model of the ball.
module tb_vga_ball_renderer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        p_tick = 1'b0;
  logic        display_on = 1'b0;
  logic        hsync_in = 1'b1;
  logic        vsync_in = 1'b1;
  logic [9:0]  x = '0;
  logic [9:0]  y = '0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic [11:0] rgb;
  logic        hsync_out;
  logic        vsync_out;

  int checks = 0;
  int errors = 0;

  vga_ball_renderer dut (
    .clk       (clk),
    .reset     (reset),
    .p_tick    (p_tick),
    .display_on(display_on),
    .hsync_in  (hsync_in),
    .vsync_in  (vsync_in),
    .x         (x),
    .y         (y),
    .start     (start),
    .pause     (pause),
    .rgb       (rgb),
    .hsync_out (hsync_out),
    .vsync_out (vsync_out)
  );

  always #5 clk = ~clk;

  localparam int ModeIdle = 0;
  localparam int ModeRun  = 1;
  localparam int ModeHold = 2;

  int          m_x, m_y, m_dx, m_dy, m_mode;
  bit          m_vprev, m_hs, m_vs;
  logic [11:0] m_rgb;

  int pdx[6] = '{-1, 0, 7, 8, 0, 7};
  int pdy[6] = '{0, 0, 7, 7, -1, 8};

  task automatic model_reset();
    m_x = 316; m_y = 236; m_dx = 1; m_dy = 1;
    m_mode = ModeIdle; m_vprev = 1'b1;
    m_rgb = 12'h000; m_hs = 1'b1; m_vs = 1'b1;
  endtask

  function automatic logic [11:0] model_rgb(int px, int py, bit disp);
    if (!disp || px >= 640 || py >= 480) return 12'h000;
    if (px == 0 || px == 639 || py == 0 || py == 479) return 12'hFFF;
    if (px >= m_x && px < m_x + 8 && py >= m_y && py < m_y + 8) return 12'hFF0;
    return 12'h008;
  endfunction

  task automatic move(inout int pos, inout int dir, input int maxp);
    if (dir > 0) begin
      if (pos + 2 >= maxp) begin pos = maxp; dir = -1; end
      else pos = pos + 2;
    end else begin
      if (pos <= 2) begin pos = 0; dir = 1; end
      else pos = pos - 2;
    end
  endtask

  // Drives one clock with the given inputs and advances the model if p_tick is set.
  task automatic tick(input int px, input int py, input bit disp, input bit hs, input bit vs,
                      input bit st, input bit pa, input bit pt);
    bit frame;
    x = 10'(px); y = 10'(py); display_on = disp; hsync_in = hs; vsync_in = vs;
    start = st; pause = pa; p_tick = pt;
    @(posedge clk);
    if (pt) begin
      m_rgb = model_rgb(px, py, disp);
      m_hs  = hs;
      m_vs  = vs;
      frame = !m_vprev && vs;
      m_vprev = vs;
      case (m_mode)
        ModeIdle: if (st) m_mode = ModeRun;
        ModeRun: begin
          if (pa) m_mode = ModeHold;
          else if (frame) begin
            move(m_x, m_dx, 632);
            move(m_y, m_dy, 472);
          end
        end
        default: if (st && !pa) m_mode = ModeRun;
      endcase
    end
    #1;
  endtask

  task automatic frame(input bit st, input bit pa);
    tick(5, 5, 1'b1, 1'b1, 1'b0, st, pa, 1'b1);
    tick(5, 5, 1'b1, 1'b1, 1'b1, st, pa, 1'b1);
  endtask

  function automatic int clampc(int v);
    return (v < 0) ? 0 : v;
  endfunction

  task automatic test_reset();
    model_reset();
    @(posedge clk); #1;
    if (rgb !== 12'h000) begin errors++; $display("FAIL reset_rgb got %h want 000", rgb); end
    checks++;
    if (hsync_out !== 1'b1) begin errors++; $display("FAIL reset_hsync got %b want 1", hsync_out); end
    checks++;
    if (vsync_out !== 1'b1) begin errors++; $display("FAIL reset_vsync got %b want 1", vsync_out); end
    checks++;
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_colour();
    int tx[9] = '{316, 100, 0, 700, 316, 639, 200, 323, 324};
    int ty[9] = '{236, 236, 50, 50, 236, 300, 479, 243, 243};
    bit td[9] = '{1, 1, 1, 1, 0, 1, 1, 1, 1};
    for (int i = 0; i < 9; i++) begin
      bit hs, vs;
      hs = 1'($urandom_range(0, 1)); vs = 1'($urandom_range(0, 1));
      tick(tx[i], ty[i], td[i], hs, vs, 1'b0, 1'b0, 1'b1);
      if (rgb !== m_rgb) begin
        errors++; $display("FAIL colour_rgb x=%0d y=%0d got %h want %h", tx[i], ty[i], rgb, m_rgb);
      end
      checks++;
      if (hsync_out !== m_hs || vsync_out !== m_vs) begin
        errors++;
        $display("FAIL colour_sync got %b%b want %b%b", hsync_out, vsync_out, m_hs, m_vs);
      end
      checks++;
    end
  endtask

  task automatic test_no_tick();
    for (int i = 0; i < 4; i++) begin
      tick(m_x, m_y, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      if (rgb !== m_rgb || hsync_out !== m_hs || vsync_out !== m_vs) begin
        errors++;
        $display("FAIL no_tick_hold got %h/%b%b want %h/%b%b", rgb, hsync_out, vsync_out,
                 m_rgb, m_hs, m_vs);
      end
      checks++;
    end
    tick(5, 5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_idle_frames();
    for (int f = 0; f < 5; f++) frame(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      int px, py;
      px = clampc(m_x + pdx[i]); py = clampc(m_y + pdy[i]);
      tick(px, py, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      if (rgb !== m_rgb) begin
        errors++; $display("FAIL idle_pos x=%0d y=%0d got %h want %h", px, py, rgb, m_rgb);
      end
      checks++;
    end
  endtask

  task automatic test_start_move();
    // start arrives on the same edge as a vsync rise: transition only, no move
    tick(5, 5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(5, 5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 6; i++) begin
        int px, py;
        px = clampc(m_x + pdx[i]); py = clampc(m_y + pdy[i]);
        tick(px, py, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        if (rgb !== m_rgb) begin
          errors++; $display("FAIL start_pos x=%0d y=%0d got %h want %h", px, py, rgb, m_rgb);
        end
        checks++;
      end
      frame(1'b0, 1'b0);
    end
  endtask

  task automatic test_bounce();
    for (int f = 0; f < 620; f++) begin
      int i, px, py;
      frame(1'b0, 1'b0);
      i = int'($urandom_range(0, 5));
      px = clampc(m_x + pdx[i]); py = clampc(m_y + pdy[i]);
      tick(px, py, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      if (rgb !== m_rgb) begin
        errors++;
        $display("FAIL bounce f=%0d x=%0d y=%0d got %h want %h", f, px, py, rgb, m_rgb);
      end
      checks++;
    end
  endtask

  task automatic test_pause();
    frame(1'b0, 1'b1);
    for (int f = 0; f < 3; f++) frame(1'b0, 1'b1);
    frame(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      int px, py;
      px = clampc(m_x + pdx[i]); py = clampc(m_y + pdy[i]);
      tick(px, py, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      if (rgb !== m_rgb) begin
        errors++; $display("FAIL pause_pos x=%0d y=%0d got %h want %h", px, py, rgb, m_rgb);
      end
      checks++;
    end
    tick(5, 5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int f = 0; f < 3; f++) frame(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      int px, py;
      px = clampc(m_x + pdx[i]); py = clampc(m_y + pdy[i]);
      tick(px, py, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      if (rgb !== m_rgb) begin
        errors++; $display("FAIL resume_pos x=%0d y=%0d got %h want %h", px, py, rgb, m_rgb);
      end
      checks++;
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      int px, py;
      bit disp, hs, vs, st, pa, pt;
      if ($urandom_range(0, 1) == 0) px = clampc(m_x + int'($urandom_range(0, 11)) - 2);
      else px = int'($urandom_range(0, 1023));
      if ($urandom_range(0, 1) == 0) py = clampc(m_y + int'($urandom_range(0, 11)) - 2);
      else py = int'($urandom_range(0, 1023));
      disp = ($urandom_range(0, 9) != 0);
      hs   = 1'($urandom_range(0, 1));
      vs   = ($urandom_range(0, 2) != 0);
      st   = ($urandom_range(0, 9) == 0);
      pa   = ($urandom_range(0, 19) == 0);
      pt   = ($urandom_range(0, 4) != 0);
      tick(px, py, disp, hs, vs, st, pa, pt);
      if (rgb !== m_rgb || hsync_out !== m_hs || vsync_out !== m_vs) begin
        errors++;
        $display("FAIL random n=%0d x=%0d y=%0d got %h/%b%b want %h/%b%b", n, px, py, rgb,
                 hsync_out, vsync_out, m_rgb, m_hs, m_vs);
      end
      checks++;
    end
  endtask

  task automatic test_reset_mid();
    tick(5, 5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int f = 0; f < 40; f++) frame(1'b0, 1'b0);
    tick(m_x, m_y, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    #1;
    model_reset();
    if (rgb !== 12'h000 || hsync_out !== 1'b1 || vsync_out !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_out got %h/%b%b want 000/11", rgb, hsync_out, vsync_out);
    end
    checks++;
    @(negedge clk); reset = 1'b0;
    for (int f = 0; f < 3; f++) frame(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      int px, py;
      px = clampc(m_x + pdx[i]); py = clampc(m_y + pdy[i]);
      tick(px, py, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      if (rgb !== m_rgb) begin
        errors++; $display("FAIL mid_reset_pos x=%0d y=%0d got %h want %h", px, py, rgb, m_rgb);
      end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_colour();
    test_no_tick();
    test_idle_frames();
    test_start_move();
    test_bounce();
    test_pause();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
